// File: rtl/mdu_sequencer_pkg.sv
// Shared types, widths and helpers for the multiply/divide unit.
package mdu_sequencer_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_FIX  = 2'd2
    } mdu_state_e;

    typedef enum logic {
        STEP_MUL = 1'b0,
        STEP_DIV = 1'b1
    } step_mode_e;

    function automatic logic op_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Magnitude of a two's-complement value; 0x80000000 maps to itself (read as unsigned)
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
        return (is_signed && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between the execute stage and the MDU.
interface mdu_sequencer_if;
    import mdu_sequencer_pkg::*;

    logic             start;
    mdu_op_e          op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort, mthi, mtlo, wdata,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort, mthi, mtlo, wdata,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/mdu_step.sv
// One iteration of shift-add multiply or restoring divide on the 2*WIDTH accumulator.
module mdu_step
    import mdu_sequencer_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] operand,
    input  step_mode_e       mode,
    output logic [ACC_W-1:0] acc_next_c
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Multiply: {product_hi, multiplier} with carry kept in add_sum[WIDTH].
    // Divide:   {remainder, dividend/quotient} shifting left one bit per step.
    always_comb begin
        add_sum = {1'b0, acc[ACC_W-1:WIDTH]} + (acc[0] ? {1'b0, operand} : (WIDTH+1)'(0));
        rem_sh  = {acc[ACC_W-1:WIDTH], acc[WIDTH-1]};
        ge      = (rem_sh >= {1'b0, operand});
        diff    = WIDTH'(rem_sh - {1'b0, operand});
        if (mode == STEP_DIV) begin
            acc_next_c = {(ge ? diff : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], ge};
        end else begin
            acc_next_c = {add_sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
(
    input logic             clk,
    input logic             reset,
    mdu_sequencer_if.slave  bus
);

    mdu_state_e       state;
    mdu_op_e          op_q;
    logic [CNT_W-1:0] counter;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] opnd;
    logic             sign_q;
    logic             sign_r;
    logic             b_zero;
    logic             busy_q;
    logic             done_q;
    logic             div0_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [ACC_W-1:0] acc_next_c;
    logic             sgn_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic [ACC_W-1:0] prod_c;
    logic [WIDTH-1:0] quot_c;
    logic [WIDTH-1:0] rem_c;
    logic [WIDTH-1:0] fix_hi_c;
    logic [WIDTH-1:0] fix_lo_c;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    mdu_step u_step (
        .acc        (acc),
        .operand    (opnd),
        .mode       (op_div(op_q) ? STEP_DIV : STEP_MUL),
        .acc_next_c (acc_next_c)
    );

    // Operand magnitudes at capture, and sign-corrected results at FIX.
    // For a zero divisor the remainder ends up holding |a|, so applying the
    // dividend sign returns the raw a.
    always_comb begin
        sgn_c   = op_signed(bus.op);
        a_mag_c = mag(bus.a, sgn_c);
        b_mag_c = mag(bus.b, sgn_c);
        prod_c  = sign_q ? ACC_W'(-acc) : acc;
        quot_c  = sign_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_c   = sign_r ? WIDTH'(-acc[ACC_W-1:WIDTH]) : acc[ACC_W-1:WIDTH];
        if (!op_div(op_q)) begin
            fix_hi_c = prod_c[ACC_W-1:WIDTH];
            fix_lo_c = prod_c[WIDTH-1:0];
        end else if (b_zero) begin
            fix_hi_c = rem_c;
            fix_lo_c = '1;
        end else begin
            fix_hi_c = rem_c;
            fix_lo_c = quot_c;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= MDU_IDLE;
            op_q    <= MDU_MULT;
            counter <= '0;
            acc     <= '0;
            opnd    <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            b_zero  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            div0_q <= 1'b0;
            unique case (state)
                MDU_IDLE: begin
                    if (bus.start) begin
                        op_q    <= bus.op;
                        counter <= '0;
                        busy_q  <= 1'b1;
                        state   <= MDU_RUN;
                        sign_q  <= sgn_c & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        sign_r  <= sgn_c & bus.a[WIDTH-1];
                        b_zero  <= (bus.b == '0);
                        if (op_div(bus.op)) begin
                            acc  <= {WIDTH'(0), a_mag_c};
                            opnd <= b_mag_c;
                        end else begin
                            acc  <= {WIDTH'(0), b_mag_c};
                            opnd <= a_mag_c;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.wdata;
                        if (bus.mtlo) lo_q <= bus.wdata;
                    end
                end
                MDU_RUN: begin
                    if (bus.abort) begin
                        state  <= MDU_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        acc     <= acc_next_c;
                        counter <= counter + CNT_W'(1);
                        if (counter == CNT_W'(WIDTH - 1)) state <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    state  <= MDU_IDLE;
                    busy_q <= 1'b0;
                    if (!bus.abort) begin
                        hi_q   <= fix_hi_c;
                        lo_q   <= fix_lo_c;
                        done_q <= 1'b1;
                        div0_q <= op_div(op_q) & b_zero;
                    end
                end
                default: begin
                    state  <= MDU_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a done-driven scoreboard.
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        div0;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic [31:0] hi_at_e0;
    logic [31:0] lo_saved;

    mdu_sequencer_if bus ();

    mdu_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (reset && bus.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h, none expected", bus.hi, bus.lo);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sb_hi", bus.hi, e.hi);
                check("sb_lo", bus.lo, e.lo);
                check("sb_div0", 32'(bus.div0), 32'(e.div0));
                check("sb_busy_low", 32'(bus.busy), 32'd0);
            end
        end
    end

    // Issue one operation and measure how long busy stays high.
    task automatic run_op(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_div0);
        int cycles;
        sb_q.push_back('{exp_hi, exp_lo, exp_div0});
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        hi_at_e0  = bus.hi;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("busy_len", 32'(cycles), 32'd33);
        @(posedge clk); #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = MDU_MULT;
        bus.a     = '0;
        bus.b     = '0;
        bus.abort = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;

        #12;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_div0", 32'(bus.div0), 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        bus.abort = 1'b1;  // abort in IDLE must not block start
        run_op(MDU_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 1'b0);
        run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op(MDU_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        run_op(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // MTHI and MTLO together, then start with a concurrent MTHI
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h5A5A_5A5A;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mthi_both", bus.hi, 32'h5A5A_5A5A);
        check("mtlo_both", bus.lo, 32'h5A5A_5A5A);
        bus.mthi  = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
        run_op(MDU_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        check("start_beats_mthi", hi_at_e0, 32'h5A5A_5A5A);

        // MTHI, then aborted MULTU with an ignored start/mthi in flight
        bus.mthi  = 1'b1;
        bus.wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        bus.mthi = 1'b0;
        check("mthi_write", bus.hi, 32'hA5A5_A5A5);
        lo_saved  = bus.lo;
        bus.op    = MDU_MULTU;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.mthi  = 1'b1;
        bus.op    = MDU_DIVU;
        bus.wdata = 32'h1111_1111;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_before_abort", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.hi, 32'hA5A5_A5A5);
        check("abort_lo", bus.lo, lo_saved);
        repeat (40) @(posedge clk);
        #1;
        check("abort_idle_busy", 32'(bus.busy), 32'd0);
        check("abort_idle_hi", bus.hi, 32'hA5A5_A5A5);

        // Asynchronous reset mid-divide
        bus.op    = MDU_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_hi", bus.hi, 32'd0);
        check("arst_lo", bus.lo, 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_op(MDU_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
